// File: rtl/fifo_pkg.sv
// Shared types and helpers for the read-side byte packer.
package fifo_pkg;

  localparam int DATA_WIDTH_DEF = 8;
  localparam int PACK_DEF       = 4;

  typedef enum logic {
    FILL = 1'b0,
    HOLD = 1'b1
  } state_e;

  // Ceiling log2, used to size counters that must hold the value v-1.
  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction

endpackage

// File: rtl/pack_accum.sv
// Lane accumulator: writes incoming entries into consecutive lanes and counts them.
// A clear empties every lane; a write on the same edge lands in lane 0.
module pack_accum
  import fifo_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int PACK       = PACK_DEF,
  localparam int CW        = clog2(PACK + 1)
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             clr,
  input  logic                             wr_en,
  input  logic [DATA_WIDTH-1:0]            wr_data,
  output logic [PACK-1:0][DATA_WIDTH-1:0]  lanes,
  output logic [CW-1:0]                    cnt
);

  localparam logic [CW-1:0] PACK_C = CW'(PACK);

  logic [CW-1:0]                   cnt_d, cnt_q, wptr;
  logic [PACK-1:0][DATA_WIDTH-1:0] lane_d, lane_q;

  always_comb begin
    wptr  = clr ? '0 : cnt_q;
    cnt_d = wptr;
    if (wr_en && (wptr < PACK_C)) cnt_d = wptr + 1'b1;
  end

  always_comb begin
    for (int k = 0; k < PACK; k++) begin
      lane_d[k] = clr ? '0 : lane_q[k];
      if (wr_en && (wptr == CW'(k))) lane_d[k] = wr_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q  <= '0;
      lane_q <= '0;
    end else begin
      cnt_q  <= cnt_d;
      lane_q <= lane_d;
    end
  end

  assign lanes = lane_q;
  assign cnt   = cnt_q;

endmodule

// File: rtl/fifo_rd_packer.sv
// Drains a 1-cycle-latency FIFO and packs PACK entries per output word (first entry in LSBs).
// Define PACKER_FLUSH_EN to flush partial words after FLUSH_CYCLES idle cycles.
module fifo_rd_packer
  import fifo_pkg::*;
#(
  parameter int DATA_WIDTH   = DATA_WIDTH_DEF,
  parameter int PACK         = PACK_DEF,
  parameter int FLUSH_CYCLES = 16
) (
  input  logic                       clkb,
  input  logic                       reset,
  input  logic                       empty,
  input  logic [DATA_WIDTH-1:0]      rdata,
  output logic                       rd_en,
  output logic [DATA_WIDTH*PACK-1:0] out_data,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [PACK-1:0]            out_keep
);

  localparam int CW = clog2(PACK + 1);
  localparam logic [CW-1:0] PACK_C = CW'(PACK);
  localparam logic [CW:0]   PACK_W = (CW+1)'(PACK);

  if (PACK < 2 || FLUSH_CYCLES < 1) begin : g_bad_cfg
    $error("fifo_rd_packer: PACK must be >= 2 and FLUSH_CYCLES >= 1");
  end

  state_e                          state_q, state_d;
  logic                            inflight_q, inflight_d;
  logic                            out_valid_q, out_valid_d;
  logic [DATA_WIDTH*PACK-1:0]      out_data_q, out_data_d;
  logic [PACK-1:0][DATA_WIDTH-1:0] acc_lanes;
  logic [CW-1:0]                   acc_cnt, eff_cnt;
  logic [CW:0]                     demand;
  logic                            out_free, xfer_full, xfer_flush, xfer;

  pack_accum #(
    .DATA_WIDTH(DATA_WIDTH),
    .PACK      (PACK)
  ) u_accum (
    .clk    (clkb),
    .rst_n  (reset),
    .clr    (xfer),
    .wr_en  (inflight_q),
    .wr_data(rdata),
    .lanes  (acc_lanes),
    .cnt    (acc_cnt)
  );

  always_ff @(posedge clkb or negedge reset) begin
    if (!reset) state_q <= FILL;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      FILL:    if (inflight_q && (acc_cnt == PACK_C - 1'b1)) state_d = HOLD;
      HOLD:    if (xfer_full) state_d = FILL;
      default: state_d = FILL;
    endcase
  end

  always_comb begin
    out_free  = !out_valid_q || out_ready;
    xfer_full = (state_q == HOLD) && out_free;
  end

  // A transfer empties the accumulator this edge, so the read budget restarts from zero now.
  assign xfer    = xfer_full | xfer_flush;
  assign eff_cnt = xfer ? '0 : acc_cnt;
  assign demand  = {1'b0, eff_cnt} + {{CW{1'b0}}, inflight_q};
  assign rd_en   = reset && !empty && (demand < PACK_W);

  assign inflight_d = rd_en;

  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    if (xfer) begin
      out_valid_d = 1'b1;
      out_data_d  = acc_lanes;
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clkb or negedge reset) begin
    if (!reset) begin
      inflight_q  <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
    end else begin
      inflight_q  <= inflight_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;

`ifdef PACKER_FLUSH_EN
  localparam int FW = clog2(FLUSH_CYCLES + 1);
  localparam logic [FW-1:0] FLUSH_C = FW'(FLUSH_CYCLES);

  logic [FW-1:0]   idle_q, idle_d;
  logic [PACK-1:0] keep_q, keep_d, fill_mask;
  logic            idle_cond;

  assign idle_cond  = (state_q == FILL) && (acc_cnt != '0) && !inflight_q && empty;
  assign xfer_flush = (state_q == FILL) && (acc_cnt != '0) && !inflight_q &&
                      (idle_q == FLUSH_C) && out_free;

  always_comb begin
    idle_d = idle_q;
    if (rd_en || xfer)                          idle_d = '0;
    else if (idle_cond && (idle_q != FLUSH_C))  idle_d = idle_q + 1'b1;
  end

  // Unfilled lanes are already zero because the accumulator clears whole lanes.
  always_comb begin
    for (int k = 0; k < PACK; k++) fill_mask[k] = (CW'(k) < acc_cnt);
    keep_d = keep_q;
    if (xfer) keep_d = xfer_flush ? fill_mask : '1;
  end

  always_ff @(posedge clkb or negedge reset) begin
    if (!reset) begin
      idle_q <= '0;
      keep_q <= '0;
    end else begin
      idle_q <= idle_d;
      keep_q <= keep_d;
    end
  end

  assign out_keep = keep_q;
`else
  assign xfer_flush = 1'b0;
  assign out_keep   = {PACK{out_valid_q}};
`endif

endmodule

// File: tb/tb_fifo_rd_packer.sv
// Bench for fifo_rd_packer: FIFO model + byte-stream scoreboard, vector table, corner sequences.
module tb_fifo_rd_packer;

  localparam int DW = 8;
  localparam int PK = 4;

  logic               clkb = 1'b0;
  logic               reset, empty, rd_en, out_valid, out_ready;
  logic [DW-1:0]      rdata;
  logic [DW*PK-1:0]   out_data;
  logic [PK-1:0]      out_keep;

  always #5 clkb = ~clkb;

  fifo_rd_packer #(.DATA_WIDTH(DW), .PACK(PK), .FLUSH_CYCLES(16)) dut (
    .clkb     (clkb),
    .reset    (reset),
    .empty    (empty),
    .rdata    (rdata),
    .rd_en    (rd_en),
    .out_data (out_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_keep (out_keep)
  );

  typedef struct {
    logic [7:0]  b0, b1, b2, b3;
    logic [31:0] w;
    logic [3:0]  k;
  } vec_t;

  vec_t        tbl[4];
  logic [7:0]  fifo[$];
  logic [7:0]  exp_b[$];
  logic [31:0] got_w[$];
  logic [3:0]  got_k[$];
  logic [7:0]  pend_d;
  logic        pend_v, hold_v, sb_en;
  logic [31:0] hold_d;
  logic [3:0]  hold_k;
  int          n_chk, n_err, pops, viol, rd_seen, ov_seen, rem;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic push_byte(input logic [7:0] b);
    fifo.push_back(b);
    exp_b.push_back(b);
  endtask

  // Every accepted word must be the next PACK bytes of the pushed stream, first byte lowest.
  task automatic sb_check(input logic [31:0] d, input logic [3:0] k);
    logic [31:0] w;
    if (exp_b.size() < PK) begin
      n_chk++; n_err++;
      $display("FAIL sb_extra_word: got %0h want none (%0d bytes left)", d, exp_b.size());
    end else begin
      w = '0;
      for (int i = 0; i < PK; i++) w[i*DW +: DW] = exp_b.pop_front();
      chk("sb_word", d, w);
      chk("sb_keep", 32'(k), 32'hF);
    end
  endtask

  // One clkb cycle: FIFO model update at negedge, sample outputs, then cross the rising edge.
  task automatic step();
    @(negedge clkb);
    if (pend_v) rdata = pend_d;
    pend_v = 1'b0;
    empty  = (fifo.size() == 0);
    #1;
    if (rd_en && empty) viol++;
    if (rd_en) rd_seen++;
    if (out_valid) ov_seen++;
    if (hold_v) begin
      chk("hold_valid", 32'(out_valid), 32'd1);
      chk("hold_data", out_data, hold_d);
      chk("hold_keep", 32'(out_keep), 32'(hold_k));
    end
    hold_v = out_valid && !out_ready;
    hold_d = out_data;
    hold_k = out_keep;
    if (rd_en && fifo.size() > 0) begin
      pend_d = fifo.pop_front();
      pend_v = 1'b1;
      pops++;
    end
    if (out_valid && out_ready) begin
      got_w.push_back(out_data);
      got_k.push_back(out_keep);
      if (sb_en) sb_check(out_data, out_keep);
    end
    @(posedge clkb);
    #1;
  endtask

  task automatic run_until(input int n, input int bound);
    for (int c = 0; c < bound && got_w.size() < n; c++) step();
  endtask

  task automatic do_reset();
    @(negedge clkb);
    reset = 1'b0;
    #1;
    chk("rst_rd_en", 32'(rd_en), 32'd0);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_data", out_data, 32'd0);
    chk("rst_out_keep", 32'(out_keep), 32'd0);
    repeat (2) @(negedge clkb);
    fifo.delete();
    exp_b.delete();
    pend_v = 1'b0;
    hold_v = 1'b0;
    empty  = 1'b1;
    @(negedge clkb);
    reset = 1'b1;
    @(posedge clkb);
    #1;
  endtask

  initial begin
    n_chk = 0; n_err = 0; pops = 0; viol = 0; rd_seen = 0; ov_seen = 0;
    reset = 1'b0; empty = 1'b1; rdata = '0; out_ready = 1'b0;
    pend_v = 1'b0; pend_d = '0; hold_v = 1'b0; hold_d = '0; hold_k = '0; sb_en = 1'b1;

    tbl[0] = '{8'h01, 8'h02, 8'h03, 8'h04, 32'h04030201, 4'hF};
    tbl[1] = '{8'h00, 8'h00, 8'h00, 8'h00, 32'h00000000, 4'hF};
    tbl[2] = '{8'hFF, 8'h00, 8'hFF, 8'h00, 32'h00FF00FF, 4'hF};
    tbl[3] = '{8'h80, 8'h7F, 8'h01, 8'hFE, 32'hFE017F80, 4'hF};

    do_reset();

    // single words with a ready sink, then idle: no reads while the FIFO is empty
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      got_w.delete(); got_k.delete(); viol = 0;
      push_byte(tbl[i].b0); push_byte(tbl[i].b1);
      push_byte(tbl[i].b2); push_byte(tbl[i].b3);
      run_until(1, 20);
      rd_seen = 0;
      repeat (5) step();
      chk("tbl_count", 32'(got_w.size()), 32'd1);
      if (got_w.size() > 0) begin
        chk("tbl_data", got_w[0], tbl[i].w);
        chk("tbl_keep", 32'(got_k[0]), 32'(tbl[i].k));
      end
      chk("tbl_rd_idle", 32'(rd_seen), 32'd0);
      chk("tbl_rd_empty", 32'(viol), 32'd0);
    end

    // back-pressure: two words buffered, then released in order
    got_w.delete(); got_k.delete(); out_ready = 1'b0; pops = 0;
    for (int i = 1; i <= 12; i++) push_byte(8'(i));
    repeat (20) step();
    chk("bp_pops", 32'(pops), 32'd8);
    chk("bp_valid", 32'(out_valid), 32'd1);
    chk("bp_hold_word", out_data, 32'h04030201);
    out_ready = 1'b1;
    step();
    chk("bp_no_bubble", 32'(out_valid), 32'd1);
    chk("bp_replace", out_data, 32'h08070605);
    run_until(3, 30);
    chk("bp_count", 32'(got_w.size()), 32'd3);
    if (got_w.size() == 3) begin
      chk("bp_word0", got_w[0], 32'h04030201);
      chk("bp_word1", got_w[1], 32'h08070605);
      chk("bp_word2", got_w[2], 32'h0C0B0A09);
    end

    // empty FIFO after reset: nothing moves
    do_reset();
    out_ready = 1'b0; rd_seen = 0; ov_seen = 0;
    repeat (50) step();
    chk("idle_rd_en", 32'(rd_seen), 32'd0);
    chk("idle_out_valid", 32'(ov_seen), 32'd0);

    // reset mid-word with a read in flight
    out_ready = 1'b1; got_w.delete(); got_k.delete(); pops = 0;
    push_byte(8'h01); push_byte(8'h02); push_byte(8'h03);
    for (int c = 0; c < 10 && pops < 3; c++) step();
    chk("mid_rst_pops", 32'(pops), 32'd3);
    do_reset();
    out_ready = 1'b1;
    push_byte(8'h11); push_byte(8'h12); push_byte(8'h13); push_byte(8'h14);
    run_until(1, 20);
    repeat (5) step();
    chk("mid_rst_count", 32'(got_w.size()), 32'd1);
    if (got_w.size() > 0) chk("mid_rst_word", got_w[0], 32'h14131211);

    // partial word followed by idle
    do_reset();
    sb_en = 1'b0; got_w.delete(); got_k.delete(); out_ready = 1'b1;
    push_byte(8'hAA); push_byte(8'hBB);
`ifdef PACKER_FLUSH_EN
    run_until(1, 60);
    chk("flush_count", 32'(got_w.size()), 32'd1);
    if (got_w.size() > 0) begin
      chk("flush_data", got_w[0], 32'h0000BBAA);
      chk("flush_keep", 32'(got_k[0]), 32'h3);
    end
`else
    repeat (60) step();
    chk("no_flush", 32'(got_w.size()), 32'd0);
`endif
    do_reset();
    sb_en = 1'b1;

    // 64-byte burst with out_ready toggling every cycle
    got_w.delete(); got_k.delete(); viol = 0;
    for (int i = 0; i < 64; i++) push_byte(8'($urandom));
    for (int c = 0; c < 400 && got_w.size() < 16; c++) begin
      out_ready = ~out_ready;
      step();
    end
    chk("burst_words", 32'(got_w.size()), 32'd16);
    chk("burst_leftover", 32'(exp_b.size()), 32'd0);
    chk("burst_rd_empty", 32'(viol), 32'd0);

    // random arrivals and random back-pressure
    got_w.delete(); got_k.delete(); viol = 0; rem = 96;
    for (int c = 0; c < 3000 && got_w.size() < 24; c++) begin
      if (rem > 0 && $urandom_range(3, 0) != 0) begin
        push_byte(8'($urandom));
        rem--;
      end
      out_ready = ($urandom_range(9, 0) < 7);
      step();
    end
    chk("rand_words", 32'(got_w.size()), 32'd24);
    chk("rand_leftover", 32'(exp_b.size()), 32'd0);
    chk("rand_rd_empty", 32'(viol), 32'd0);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
